clock_tick_gen: RTL and testbench
=================================

# clock_tick_gen

Parametrised multi-channel successor to the team's fixed two-flag clock divider. It generates NUM_CH independent tick outputs from one system clock. Each channel has a run-time programmable divisor and a mode: one-cycle pulse or 50%-style toggle. Configuration changes are shadowed and take effect only at a period boundary, so a running output never glitches. The block sits beside the pixel/pulse timing logic and feeds any consumer that needs a programmable strobe rate.

## Interface
Parameters:
- NUM_CH, 4: number of channels (1–16).
- DIV_W, 8: divisor width in bits.
- RST_DIV, 4: divisor loaded into every channel at reset (must be < 2**DIV_W).

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- n_rst  input  1  asynchronous, active-low reset.
- enable  input  1  global count enable; when low, all counters and outputs hold.
- sync_clear  input  1  synchronous realign of all channels (single-cycle strobe).
- cfg_load  input  1  write strobe for one channel's configuration.
- cfg_ch  input  $clog2(NUM_CH) (min 1)  target channel for cfg_load.
- cfg_div  input  DIV_W  new divisor D.
- cfg_mode  input  1  0 = PULSE, 1 = TOGGLE.
- tick_out  output  NUM_CH  per-channel output, selected by the active mode.
- cfg_pending  output  NUM_CH  high while a loaded configuration has not yet taken effect.

## Operation
- Per-channel state: cnt[DIV_W], active_div, active_mode, pend_div, pend_mode, pend_valid, out register.
- Counting (enable=1, active_div=D≥1): cnt steps 0..D-1. The wrap cycle is cnt==D-1. On a wrap cycle, cnt returns to 0.
- PULSE mode: out is registered high for exactly the cycle after each wrap cycle and low otherwise. D=1 gives out continuously high.
- TOGGLE mode: out inverts on the cycle after each wrap cycle. The output period is 2·D cycles.
- D=0: the channel is halted. cnt is held at 0. PULSE out=0; TOGGLE out holds its current value.
- enable=0: cnt holds, TOGGLE out holds, PULSE out is 0. Pending configuration is not applied.
- cfg_load captures cfg_div/cfg_mode into pend_* of channel cfg_ch and sets pend_valid. A second load before application overwrites it (last write wins). An out-of-range cfg_ch is ignored.
- Application: pend_* is copied to active_* and pend_valid clears at the first of these events:
  - a wrap cycle with enable=1;
  - any cycle while active_div==0;
  - sync_clear.
- After application, cnt restarts from 0 with the new D.
- Mode change at application: PULSE→TOGGLE starts with out=0. TOGGLE→PULSE forces out=0.
- sync_clear (highest priority after reset):
  - every cnt=0 and every out=0;
  - all pending configuration is applied;
  - a cfg_load in the same cycle is applied immediately to its channel, as if it were already pending.
- cfg_load on a channel in its wrap cycle: the old pend value is applied, and the new load becomes pending.

## Timing
- Reset (n_rst=0): cnt=0, active_div=RST_DIV, active_mode=PULSE, pend_valid=0, tick_out=0, cfg_pending=0.
- Latency: with sync_clear in cycle k and enable=1 from k+1, the first PULSE is high in cycle k+D+1. Subsequent pulses occur at k+D+1+n·D.
- cfg_pending rises the cycle after cfg_load. It falls the cycle after application.
- All outputs are registered; there is no combinational input-to-output path.
- Reset asserted mid-period aborts immediately. Pending configuration is discarded.

## Structure
- Package tick_pkg holds:
  - typedef enum logic {TICK_PULSE, TICK_TOGGLE} tick_mode_t;
  - the default-width constants shared with consumers.
- Sub-module tick_channel holds one channel's counter, shadow registers and output logic. The top instantiates NUM_CH copies via generate and decodes cfg_load/cfg_ch into per-channel load strobes.

## Test plan
- Reset, then enable=1 with default config (RST_DIV=4): every channel pulses in cycles 5, 9, 13… after reset release, with tick_out=0 and cfg_pending=0 while in reset.
- Load ch1 D=3, TOGGLE during cnt=1 of a D=4 period: the old period completes, cfg_pending[1] is high until the wrap, then out toggles every 3 cycles (period 6).
- Load ch2 D=0: the channel halts with out low. Then load D=2: it applies the next cycle and pulses every 2 cycles.
- enable low for 5 cycles mid-period: cnt and TOGGLE level freeze, PULSE stays 0, and the phase resumes exactly afterwards.
- sync_clear together with cfg_load ch0 D=5: all outputs 0 the next cycle, ch0 runs D=5 immediately, and the other channels realign with their first pulse at k+D+1.
- Two loads to ch3 (D=7, then D=2) before its wrap: only D=2 is applied. A load with cfg_ch ≥ NUM_CH changes nothing.

Source files
------------

// File: rtl/tick_pkg.sv
// Shared types and default sizing for the programmable tick generator.
// Consumers import this package so that the widths agree with the generator.
package tick_pkg;

  typedef enum logic {TICK_PULSE, TICK_TOGGLE} tick_mode_t;

  localparam int DEF_NUM_CH  = 4;
  localparam int DEF_DIV_W   = 8;
  localparam int DEF_RST_DIV = 4;

  // Width of a channel index; a single channel still gets a 1-bit select.
  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tick_channel.sv
// One channel of the tick generator: period counter, shadowed configuration
// and the registered output.
//   clk, n_rst   : system clock, asynchronous active-low reset
//   enable       : count enable; low freezes the counter and toggle level
//   sync_clear   : realign strobe; zeroes counter/output, applies config
//   load         : write strobe for this channel (already decoded)
//   cfg_div      : new divisor
//   cfg_mode     : new output mode
//   tick         : registered channel output
//   pending      : a loaded configuration is waiting for a period boundary
module tick_channel
  import tick_pkg::*;
#(
  parameter int DIV_W   = DEF_DIV_W,
  parameter int RST_DIV = DEF_RST_DIV
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             enable,
  input  logic             sync_clear,
  input  logic             load,
  input  logic [DIV_W-1:0] cfg_div,
  input  tick_mode_t       cfg_mode,
  output logic             tick,
  output logic             pending
);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] active_div;
  logic [DIV_W-1:0] pend_div;
  tick_mode_t       active_mode;
  tick_mode_t       pend_mode;
  logic             pend_valid;
  logic             out_q;

  logic halted;
  logic wrap;
  logic apply;

  assign halted = (active_div == '0);
  assign wrap   = enable && !halted && (cnt == active_div - DIV_W'(1));
  // A halted channel has no boundary to wait for, so it accepts new
  // configuration on any enabled cycle.
  assign apply  = enable && pend_valid && (wrap || halted);

  // NOTE: every register here is updated with <= so all channel state moves
  // together on the edge; mixing in = would make the order of lines matter.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt         <= '0;
      active_div  <= DIV_W'(RST_DIV);
      active_mode <= TICK_PULSE;
      pend_div    <= '0;
      pend_mode   <= TICK_PULSE;
      pend_valid  <= 1'b0;
      out_q       <= 1'b0;
    end else if (sync_clear) begin
      cnt        <= '0;
      out_q      <= 1'b0;
      pend_valid <= 1'b0;
      // A load in the same cycle wins over an older pending value.
      if (load) begin
        active_div  <= cfg_div;
        active_mode <= cfg_mode;
      end else if (pend_valid) begin
        active_div  <= pend_div;
        active_mode <= pend_mode;
      end
    end else begin
      if (apply) begin
        active_div  <= pend_div;
        active_mode <= pend_mode;
        pend_valid  <= 1'b0;
        cnt         <= '0;
        // The closing period still produces its own edge unless the mode
        // changes, in which case the new mode starts from a clean low.
        if (pend_mode != active_mode)   out_q <= 1'b0;
        else if (active_mode == TICK_PULSE) out_q <= wrap;
        else                            out_q <= out_q ^ wrap;
      end else if (enable) begin
        cnt <= (wrap || halted) ? '0 : cnt + DIV_W'(1);
        if (active_mode == TICK_PULSE) out_q <= wrap;
        else                           out_q <= out_q ^ wrap;
      end else if (active_mode == TICK_PULSE) begin
        out_q <= 1'b0;
      end
      // Placed after the apply branch so a load in a wrap cycle becomes the
      // next pending value instead of being lost.
      if (load) begin
        pend_div   <= cfg_div;
        pend_mode  <= cfg_mode;
        pend_valid <= 1'b1;
      end
    end
  end

  assign tick    = out_q;
  assign pending = pend_valid;

endmodule

// File: rtl/clock_tick_gen.sv
// Multi-channel programmable tick generator. Each channel divides clk by its
// own run-time divisor and drives either a one-cycle pulse or a toggle.
//   clk, n_rst   : system clock, asynchronous active-low reset
//   enable       : global count enable
//   sync_clear   : realign all channels and apply pending configuration
//   cfg_load     : configuration write strobe for channel cfg_ch
//   cfg_ch       : target channel; values >= NUM_CH are ignored
//   cfg_div      : new divisor (0 halts the channel)
//   cfg_mode     : 0 = pulse, 1 = toggle
//   tick_out     : registered per-channel outputs
//   cfg_pending  : per-channel flag for configuration not yet applied
module clock_tick_gen
  import tick_pkg::*;
#(
  parameter int  NUM_CH  = DEF_NUM_CH,
  parameter int  DIV_W   = DEF_DIV_W,
  parameter int  RST_DIV = DEF_RST_DIV,
  localparam int CH_W    = ch_width(NUM_CH)
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              enable,
  input  logic              sync_clear,
  input  logic              cfg_load,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic              cfg_mode,
  output logic [NUM_CH-1:0] tick_out,
  output logic [NUM_CH-1:0] cfg_pending
);

  tick_mode_t mode_in;
  assign mode_in = tick_mode_t'(cfg_mode);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic load_i;
    // Indices beyond NUM_CH match no channel, so such writes are dropped.
    assign load_i = cfg_load && (cfg_ch == CH_W'(i));

    tick_channel #(
      .DIV_W   (DIV_W),
      .RST_DIV (RST_DIV)
    ) u_ch (
      .clk        (clk),
      .n_rst      (n_rst),
      .enable     (enable),
      .sync_clear (sync_clear),
      .load       (load_i),
      .cfg_div    (cfg_div),
      .cfg_mode   (mode_in),
      .tick       (tick_out[i]),
      .pending    (cfg_pending[i])
    );
  end

endmodule

// File: tb/tb_clock_tick_gen.sv
// Self-checking bench for clock_tick_gen with a behavioural channel model.
module tb_clock_tick_gen;

  localparam int NUM_CH  = 5;
  localparam int DIV_W   = 8;
  localparam int RST_DIV = 4;
  localparam int CH_W    = 3;

  logic              clk = 1'b0;
  logic              n_rst;
  logic              enable;
  logic              sync_clear;
  logic              cfg_load;
  logic [CH_W-1:0]   cfg_ch;
  logic [DIV_W-1:0]  cfg_div;
  logic              cfg_mode;
  logic [NUM_CH-1:0] tick_out;
  logic [NUM_CH-1:0] cfg_pending;

  int checks = 0;
  int errors = 0;

  clock_tick_gen #(
    .NUM_CH  (NUM_CH),
    .DIV_W   (DIV_W),
    .RST_DIV (RST_DIV)
  ) dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .enable      (enable),
    .sync_clear  (sync_clear),
    .cfg_load    (cfg_load),
    .cfg_ch      (cfg_ch),
    .cfg_div     (cfg_div),
    .cfg_mode    (cfg_mode),
    .tick_out    (tick_out),
    .cfg_pending (cfg_pending)
  );

  always #5 clk = ~clk;

  // Model: each channel is described by its divisor, mode, how many cycles
  // of the current period have elapsed, its output level and a pending slot.
  typedef struct {
    int div;
    bit toggle;
    int pos;
    bit lvl;
    bit pv;
    int pdiv;
    bit ptoggle;
  } chan_m_t;

  chan_m_t           m [NUM_CH];
  logic [NUM_CH-1:0] m_tick;
  logic [NUM_CH-1:0] m_pend;

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m[c] = '{div: RST_DIV, toggle: 1'b0, pos: 0, lvl: 1'b0, pv: 1'b0, pdiv: 0, ptoggle: 1'b0};
    end
    m_tick = '0;
    m_pend = '0;
  endtask

  task automatic model_step(input bit en, input bit sc, input bit ld, input int ch,
                            input int dv, input bit md);
    for (int c = 0; c < NUM_CH; c++) begin
      bit mine, ends, swap, nl;
      mine = ld && (ch == c);
      if (sc) begin
        if (mine) begin
          m[c].div = dv; m[c].toggle = md;
        end else if (m[c].pv) begin
          m[c].div = m[c].pdiv; m[c].toggle = m[c].ptoggle;
        end
        m[c].pos = 0; m[c].lvl = 1'b0; m[c].pv = 1'b0;
      end else begin
        ends = en && (m[c].div > 0) && (m[c].pos == m[c].div - 1);
        swap = en && m[c].pv && (ends || m[c].div == 0);
        if (!en) nl = m[c].toggle ? m[c].lvl : 1'b0;
        else     nl = m[c].toggle ? (m[c].lvl ^ ends) : ends;
        if (swap) begin
          if (m[c].ptoggle != m[c].toggle) nl = 1'b0;
          m[c].div = m[c].pdiv; m[c].toggle = m[c].ptoggle;
          m[c].pv = 1'b0; m[c].pos = 0;
        end else if (en && m[c].div > 0) begin
          m[c].pos = (m[c].pos + 1) % m[c].div;
        end
        m[c].lvl = nl;
        if (mine) begin
          m[c].pdiv = dv; m[c].ptoggle = md; m[c].pv = 1'b1;
        end
      end
      m_tick[c] = m[c].lvl;
      m_pend[c] = m[c].pv;
    end
  endtask

  // One clock: drive inputs, advance model on the edge, settle 1 time unit.
  task automatic tick(input bit en, input bit sc = 1'b0, input bit ld = 1'b0,
                      input int ch = 0, input int dv = 0, input bit md = 1'b0);
    enable     = en;
    sync_clear = sc;
    cfg_load   = ld;
    cfg_ch     = CH_W'(ch);
    cfg_div    = DIV_W'(dv);
    cfg_mode   = md;
    @(posedge clk);
    model_step(en, sc, ld, ch, dv, md);
    #1;
    sync_clear = 1'b0;
    cfg_load   = 1'b0;
  endtask

  task automatic test_reset();
    logic [NUM_CH-1:0] exp_t;
    n_rst = 1'b0; enable = 1'b0; sync_clear = 1'b0; cfg_load = 1'b0;
    cfg_ch = '0; cfg_div = '0; cfg_mode = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (tick_out !== '0 || cfg_pending !== '0) begin
      errors++;
      $display("FAIL reset_hold tick_out=%b exp=0 cfg_pending=%b exp=0", tick_out, cfg_pending);
    end
    n_rst = 1'b1;
    // Sample after edge e shows cycle e+1: pulses in cycles 5, 9, 13.
    for (int e = 1; e <= 16; e++) begin
      tick(1'b1);
      exp_t = (e % 4 == 0) ? '1 : '0;
      checks++;
      if (tick_out !== exp_t || cfg_pending !== '0) begin
        errors++;
        $display("FAIL reset_default e=%0d tick_out=%b exp=%b cfg_pending=%b exp=0",
                 e, tick_out, exp_t, cfg_pending);
      end
    end
  endtask

  task automatic test_toggle_load();
    bit exp_p, exp_l;
    for (int i = 0; i < 8 && m[1].pos != 1; i++) tick(1'b1);
    tick(1'b1, 1'b0, 1'b1, 1, 3, 1'b1);
    for (int j = 0; j <= 14; j++) begin
      if (j > 0) tick(1'b1);
      exp_p = (j < 2);
      exp_l = (j < 2) ? 1'b0 : 1'(((j - 2) / 3) % 2);
      checks++;
      if (tick_out[1] !== exp_l || cfg_pending[1] !== exp_p ||
          tick_out !== m_tick || cfg_pending !== m_pend) begin
        errors++;
        $display("FAIL toggle_load j=%0d tick_out=%b exp=%b cfg_pending=%b exp=%b",
                 j, tick_out, m_tick, cfg_pending, m_pend);
      end
    end
  endtask

  task automatic test_halt();
    bit exp_l;
    tick(1'b1, 1'b0, 1'b1, 2, 0, 1'b0);
    for (int i = 0; i < 8 && m[2].pv; i++) begin
      tick(1'b1);
      checks++;
      if (tick_out !== m_tick || cfg_pending !== m_pend) begin
        errors++;
        $display("FAIL halt_apply tick_out=%b exp=%b cfg_pending=%b exp=%b",
                 tick_out, m_tick, cfg_pending, m_pend);
      end
    end
    tick(1'b1);
    for (int i = 0; i < 5; i++) begin
      tick(1'b1);
      checks++;
      if (tick_out[2] !== 1'b0 || tick_out !== m_tick) begin
        errors++;
        $display("FAIL halt_low tick_out=%b exp=%b", tick_out, m_tick);
      end
    end
    tick(1'b1, 1'b0, 1'b1, 2, 2, 1'b0);
    for (int j = 0; j <= 10; j++) begin
      if (j > 0) tick(1'b1);
      exp_l = (j >= 3) && ((j - 3) % 2 == 0);
      checks++;
      if (tick_out[2] !== exp_l || cfg_pending[2] !== (j == 0) ||
          tick_out !== m_tick || cfg_pending !== m_pend) begin
        errors++;
        $display("FAIL halt_resume j=%0d tick_out=%b exp=%b cfg_pending=%b exp=%b",
                 j, tick_out, m_tick, cfg_pending, m_pend);
      end
    end
  endtask

  task automatic test_enable_freeze();
    bit frozen;
    repeat ($urandom_range(1, 5)) tick(1'b1);
    frozen = m_tick[1];
    for (int i = 0; i < 5; i++) begin
      tick(1'b0);
      checks++;
      if (tick_out[1] !== frozen || (tick_out & ~5'b00010) !== '0 || tick_out !== m_tick) begin
        errors++;
        $display("FAIL enable_freeze i=%0d tick_out=%b exp=%b", i, tick_out, m_tick);
      end
    end
    for (int i = 0; i < 12; i++) begin
      tick(1'b1);
      checks++;
      if (tick_out !== m_tick || cfg_pending !== m_pend) begin
        errors++;
        $display("FAIL enable_resume i=%0d tick_out=%b exp=%b", i, tick_out, m_tick);
      end
    end
  endtask

  task automatic test_sync_clear();
    tick(1'b1, 1'b1, 1'b1, 0, 5, 1'b0);
    checks++;
    if (tick_out !== '0 || cfg_pending !== '0) begin
      errors++;
      $display("FAIL sync_clear_zero tick_out=%b exp=0 cfg_pending=%b exp=0", tick_out, cfg_pending);
    end
    for (int j = 1; j <= 15; j++) begin
      tick(1'b1);
      checks++;
      if (tick_out[0] !== (j % 5 == 0) || tick_out[4] !== (j % 4 == 0) ||
          tick_out !== m_tick || cfg_pending !== m_pend) begin
        errors++;
        $display("FAIL sync_clear_align j=%0d tick_out=%b exp=%b", j, tick_out, m_tick);
      end
    end
  endtask

  task automatic test_last_write();
    bit exp_l;
    for (int i = 0; i < 8 && m[3].pos != 0; i++) tick(1'b1);
    tick(1'b1, 1'b0, 1'b1, 3, 7, 1'b0);
    tick(1'b1, 1'b0, 1'b1, 3, 2, 1'b0);
    tick(1'b1, 1'b0, 1'b1, 6, 1, 1'b1);
    for (int j = 2; j <= 12; j++) begin
      if (j > 2) tick(1'b1);
      exp_l = (j >= 3) && ((j - 3) % 2 == 0);
      checks++;
      if (tick_out[3] !== exp_l || cfg_pending[3] !== (j < 3) ||
          tick_out !== m_tick || cfg_pending !== m_pend) begin
        errors++;
        $display("FAIL last_write j=%0d tick_out=%b exp=%b cfg_pending=%b exp=%b",
                 j, tick_out, m_tick, cfg_pending, m_pend);
      end
    end
  endtask

  task automatic test_random();
    bit en, sc, ld;
    for (int i = 0; i < 400; i++) begin
      en = ($urandom_range(0, 7) != 0);
      sc = ($urandom_range(0, 39) == 0);
      ld = ($urandom_range(0, 5) == 0);
      tick(en, sc, ld, $urandom_range(0, 7), $urandom_range(0, 9), 1'($urandom_range(0, 1)));
      checks++;
      if (tick_out !== m_tick || cfg_pending !== m_pend) begin
        errors++;
        $display("FAIL random i=%0d tick_out=%b exp=%b cfg_pending=%b exp=%b",
                 i, tick_out, m_tick, cfg_pending, m_pend);
      end
    end
  endtask

  task automatic test_reset_abort();
    tick(1'b1, 1'b0, 1'b1, 4, 9, 1'b1);
    tick(1'b1, 1'b0, 1'b1, 1, 1, 1'b0);
    #2 n_rst = 1'b0;
    #1;
    model_reset();
    checks++;
    if (tick_out !== '0 || cfg_pending !== '0) begin
      errors++;
      $display("FAIL reset_abort tick_out=%b exp=0 cfg_pending=%b exp=0", tick_out, cfg_pending);
    end
    @(posedge clk);
    #1 n_rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(1'b1);
      checks++;
      if (tick_out !== m_tick || cfg_pending !== m_pend) begin
        errors++;
        $display("FAIL reset_restart i=%0d tick_out=%b exp=%b cfg_pending=%b exp=%b",
                 i, tick_out, m_tick, cfg_pending, m_pend);
      end
    end
  endtask

  initial begin
    test_reset();
    test_toggle_load();
    test_halt();
    test_enable_freeze();
    test_sync_clear();
    test_last_write();
    test_random();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
